// File: rtl/fft8_frame_ctrl.sv
// fft8_frame_ctrl: sequencing controller around an 8-point FFT core.
// Gathers one 8-sample frame from a valid/ready stream, presents it in
// parallel to the core, enables the core for its pipeline latency,
// captures the 8 bins and streams them back out with backpressure.
// Malformed frames (short or long) raise a one-cycle frame_err and the
// controller resynchronises on the next s_last.
module fft8_frame_ctrl #(
    parameter int IN_W    = 8,
    parameter int OUT_W   = 11,
    parameter int FFT_LAT = 2,
    parameter int CNT_W   = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    // input sample stream
    input  logic                 s_valid,
    output logic                 s_ready,
    input  logic [IN_W-1:0]      s_re,
    input  logic [IN_W-1:0]      s_im,
    input  logic                 s_last,
    // FFT core interface
    output logic                 fft_en,
    output logic [8*IN_W-1:0]    fft_i_re,
    output logic [8*IN_W-1:0]    fft_i_im,
    input  logic [8*OUT_W-1:0]   fft_o_re,
    input  logic [8*OUT_W-1:0]   fft_o_im,
    // result stream
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic [OUT_W-1:0]     m_re,
    output logic [OUT_W-1:0]     m_im,
    output logic [2:0]           m_idx,
    output logic                 m_last,
    // status
    output logic                 busy,
    output logic                 frame_err,
    output logic [CNT_W-1:0]     frame_cnt
);

    localparam int LAT_W = (FFT_LAT < 2) ? 1 : $clog2(FFT_LAT);
    localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(FFT_LAT - 1);

    typedef enum logic [2:0] {
        LOAD   = 3'd0,
        SYNC   = 3'd1,
        RUN    = 3'd2,
        CAP    = 3'd3,
        UNLOAD = 3'd4
    } state_t;

    state_t             state;
    state_t             next_state;
    logic [2:0]         wr_cnt;
    logic [2:0]         rd_cnt;
    logic [LAT_W-1:0]   lat_cnt;
    logic               s_ready_q;
    logic               frame_err_q;
    logic [CNT_W-1:0]   frame_cnt_q;

    logic [IN_W-1:0]    in_re  [8];
    logic [IN_W-1:0]    in_im  [8];
    logic [OUT_W-1:0]   out_re [8];
    logic [OUT_W-1:0]   out_im [8];

    // Decoded events used by both the next-state logic and the registers.
    logic accept;
    logic in_last_slot;
    logic short_frame;
    logic long_frame;
    logic out_hs;
    logic out_done;

    assign accept       = s_valid && s_ready_q;
    assign in_last_slot = (wr_cnt == 3'd7);
    assign short_frame  = (state == LOAD) && accept && s_last && !in_last_slot;
    assign long_frame   = (state == LOAD) && accept && !s_last && in_last_slot;
    assign out_hs       = (state == UNLOAD) && m_ready;
    assign out_done     = out_hs && (rd_cnt == 3'd7);

    // Next-state selection; every path starts from the hold default.
    // NOTE: the default assignment at the top of an always_comb is what keeps
    // a case arm that forgets a target from turning into a latch.
    always_comb begin
        next_state = state;
        case (state)
            LOAD: begin
                if (accept && in_last_slot) begin
                    next_state = s_last ? RUN : SYNC;
                end
            end
            SYNC: begin
                if (accept && s_last) begin
                    next_state = LOAD;
                end
            end
            RUN: begin
                if (lat_cnt == LAT_LAST) begin
                    next_state = CAP;
                end
            end
            CAP: begin
                next_state = UNLOAD;
            end
            UNLOAD: begin
                if (out_done) begin
                    next_state = LOAD;
                end
            end
            default: begin
                next_state = LOAD;
            end
        endcase
    end

    // State register plus all control counters and status flags.
    // NOTE: registered state uses non-blocking assignments so every flop in
    // this block sees the pre-edge values of its neighbours.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= LOAD;
            wr_cnt      <= 3'd0;
            rd_cnt      <= 3'd0;
            lat_cnt     <= '0;
            s_ready_q   <= 1'b0;
            frame_err_q <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            state <= next_state;

            // s_ready is registered from the upcoming state so it is low in
            // reset and rises on the first edge afterwards.
            s_ready_q <= (next_state == LOAD) || (next_state == SYNC);

            frame_err_q <= short_frame || long_frame;

            if (state == LOAD && accept) begin
                if (s_last || in_last_slot) begin
                    wr_cnt <= 3'd0;
                end else begin
                    wr_cnt <= wr_cnt + 3'd1;
                end
            end else if (state == SYNC) begin
                wr_cnt <= 3'd0;
            end

            if (state == RUN) begin
                lat_cnt <= lat_cnt + LAT_W'(1);
            end else begin
                lat_cnt <= '0;
            end

            if (state == CAP) begin
                rd_cnt <= 3'd0;
            end else if (out_hs) begin
                rd_cnt <= rd_cnt + 3'd1;
            end

            if (out_done) begin
                frame_cnt_q <= frame_cnt_q + CNT_W'(1);
            end
        end
    end

    // Frame buffers: input samples land by slot, core results by bin.
    // NOTE: these buffers sit on the async reset so a frame aborted by reset
    // can never leak stale samples or bins into the next one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < 8; k++) begin
                in_re[k]  <= '0;
                in_im[k]  <= '0;
                out_re[k] <= '0;
                out_im[k] <= '0;
            end
        end else begin
            // A short-frame terminator is discarded rather than stored.
            if (state == LOAD && accept && !short_frame) begin
                in_re[wr_cnt] <= s_re;
                in_im[wr_cnt] <= s_im;
            end
            if (state == CAP) begin
                for (int k = 0; k < 8; k++) begin
                    out_re[k] <= fft_o_re[k*OUT_W +: OUT_W];
                    out_im[k] <= fft_o_im[k*OUT_W +: OUT_W];
                end
            end
        end
    end

    // Parallel core inputs come straight from the input buffer registers,
    // so they cannot move while RUN holds them.
    always_comb begin
        fft_i_re = '0;
        fft_i_im = '0;
        for (int k = 0; k < 8; k++) begin
            fft_i_re[k*IN_W +: IN_W] = in_re[k];
            fft_i_im[k*IN_W +: IN_W] = in_im[k];
        end
    end

    // Output side: bin selected by rd_cnt, which only moves on a handshake,
    // so data and index hold steady under backpressure.
    always_comb begin
        m_valid = (state == UNLOAD);
        m_re    = out_re[rd_cnt];
        m_im    = out_im[rd_cnt];
        m_idx   = rd_cnt;
        m_last  = (state == UNLOAD) && (rd_cnt == 3'd7);
    end

    assign s_ready   = s_ready_q;
    assign fft_en    = (state == RUN);
    assign busy      = (state != LOAD) && (state != SYNC);
    assign frame_err = frame_err_q;
    assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_fft8_frame_ctrl.sv
// tb_fft8_frame_ctrl: directed bench for fft8_frame_ctrl with a behavioural
// 8-point DFT standing in for the core (two enabled pipeline stages).
module tb_fft8_frame_ctrl;

    localparam int IN_W  = 8;
    localparam int OUT_W = 11;
    localparam int CNT_W = 16;

    logic                clk;
    logic                rst;
    logic                s_valid;
    logic                s_ready;
    logic [IN_W-1:0]     s_re;
    logic [IN_W-1:0]     s_im;
    logic                s_last;
    logic                fft_en;
    logic [8*IN_W-1:0]   fft_i_re;
    logic [8*IN_W-1:0]   fft_i_im;
    logic [8*OUT_W-1:0]  fft_o_re;
    logic [8*OUT_W-1:0]  fft_o_im;
    logic                m_valid;
    logic                m_ready;
    logic [OUT_W-1:0]    m_re;
    logic [OUT_W-1:0]    m_im;
    logic [2:0]          m_idx;
    logic                m_last;
    logic                busy;
    logic                frame_err;
    logic [CNT_W-1:0]    frame_cnt;

    fft8_frame_ctrl #(
        .IN_W(IN_W), .OUT_W(OUT_W), .FFT_LAT(2), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst),
        .s_valid(s_valid), .s_ready(s_ready), .s_re(s_re), .s_im(s_im), .s_last(s_last),
        .fft_en(fft_en), .fft_i_re(fft_i_re), .fft_i_im(fft_i_im),
        .fft_o_re(fft_o_re), .fft_o_im(fft_o_im),
        .m_valid(m_valid), .m_ready(m_ready), .m_re(m_re), .m_im(m_im),
        .m_idx(m_idx), .m_last(m_last),
        .busy(busy), .frame_err(frame_err), .frame_cnt(frame_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- behavioural FFT core ----------------
    function automatic logic [OUT_W-1:0] rnd(input real v);
        int r;
        r = (v >= 0.0) ? $rtoi(v + 0.5) : $rtoi(v - 0.5);
        return r[OUT_W-1:0];
    endfunction

    function automatic logic [8*OUT_W-1:0] dft(input logic [8*IN_W-1:0] xr_v,
                                               input logic [8*IN_W-1:0] xi_v,
                                               input bit want_im);
        logic [8*OUT_W-1:0] r;
        real ar, ai, ang, xr, xi;
        r = '0;
        for (int k = 0; k < 8; k++) begin
            ar = 0.0;
            ai = 0.0;
            for (int n = 0; n < 8; n++) begin
                xr  = real'($signed(xr_v[n*IN_W +: IN_W]));
                xi  = real'($signed(xi_v[n*IN_W +: IN_W]));
                ang = 2.0 * 3.14159265358979 * real'(n * k) / 8.0;
                ar  = ar + xr * $cos(ang) + xi * $sin(ang);
                ai  = ai + xi * $cos(ang) - xr * $sin(ang);
            end
            r[k*OUT_W +: OUT_W] = want_im ? rnd(ai) : rnd(ar);
        end
        return r;
    endfunction

    logic [8*OUT_W-1:0] st1_re, st1_im, st2_re, st2_im;
    always @(posedge clk) begin
        if (fft_en) begin
            st1_re <= dft(fft_i_re, fft_i_im, 1'b0);
            st1_im <= dft(fft_i_re, fft_i_im, 1'b1);
            st2_re <= st1_re;
            st2_im <= st1_im;
        end
    end
    assign fft_o_re = st2_re;
    assign fft_o_im = st2_im;

    // ---------------- checking ----------------
    int compared = 0;
    int mismatched = 0;

    task automatic check(input string tag, input int act, input int exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Free-running monitors sampled on the falling edge.
    int en_cycles = 0;
    int err_cycles = 0;
    int viol = 0;
    always @(negedge clk) begin
        if (fft_en) en_cycles++;
        if (frame_err) err_cycles++;
        if (busy && s_ready) viol++;
        if (fft_en && (s_ready || m_valid)) viol++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus helpers ----------------
    int tx_re [16];
    int tx_im [16];
    int exp_re [8];
    int exp_im [8];

    // mode 0: impulse 64; 1: DC 10; 2: x[4]=20; 3: x[2]=16
    task automatic set_frame(input int mode);
        for (int i = 0; i < 8; i++) begin
            tx_re[i] = 0; tx_im[i] = 0; exp_re[i] = 0; exp_im[i] = 0;
        end
        case (mode)
            0: begin
                tx_re[0] = 64;
                for (int i = 0; i < 8; i++) exp_re[i] = 64;
            end
            1: begin
                for (int i = 0; i < 8; i++) tx_re[i] = 10;
                exp_re[0] = 80;
            end
            2: begin
                tx_re[4] = 20;
                for (int i = 0; i < 8; i++) exp_re[i] = (i % 2 == 0) ? 20 : -20;
            end
            default: begin
                tx_re[2] = 16;
                exp_re[0] = 16;  exp_re[2] = -16; exp_re[4] = 16;  exp_re[6] = -16;
                exp_im[1] = -16; exp_im[3] = 16;  exp_im[5] = -16; exp_im[7] = 16;
            end
        endcase
    endtask

    // Present one sample; returns at the falling edge after it was accepted.
    task automatic push(input int re, input int im, input bit last);
        int n;
        n = 0;
        s_valid = 1'b1;
        s_re    = re[IN_W-1:0];
        s_im    = im[IN_W-1:0];
        s_last  = last;
        while (!s_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) check("push_ready", int'(s_ready), 1);
        @(negedge clk);
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic send(input int n, input int last_at);
        for (int i = 0; i < n; i++) push(tx_re[i], tx_im[i], i == last_at);
    endtask

    // Collect up to max_hs results, checking each bin and stall stability.
    task automatic pull(input string tag, input int max_hs, input bit bp);
        int hs, cyc, h_re, h_im, h_idx;
        bit held;
        hs = 0; cyc = 0; held = 0; h_re = 0; h_im = 0; h_idx = 0;
        while (hs < max_hs && cyc < 200) begin
            m_ready = bp ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
            if (held) begin
                check({tag, "_stall_valid"}, int'(m_valid), 1);
                check({tag, "_stall_re"}, int'($signed(m_re)), h_re);
                check({tag, "_stall_im"}, int'($signed(m_im)), h_im);
                check({tag, "_stall_idx"}, int'(m_idx), h_idx);
            end
            if (m_valid && m_ready) begin
                check({tag, "_idx"}, int'(m_idx), hs);
                check({tag, "_re"}, int'($signed(m_re)), exp_re[hs]);
                check({tag, "_im"}, int'($signed(m_im)), exp_im[hs]);
                check({tag, "_last"}, int'(m_last), int'(hs == 7));
                hs++;
                held = 0;
            end else if (m_valid) begin
                held  = 1;
                h_re  = int'($signed(m_re));
                h_im  = int'($signed(m_im));
                h_idx = int'(m_idx);
            end else begin
                held = 0;
            end
            cyc++;
            @(negedge clk);
        end
        check({tag, "_handshakes"}, hs, max_hs);
        m_ready = 1'b0;
    endtask

    int en0, err0;

    initial begin
        rst = 1'b1; s_valid = 1'b0; s_re = '0; s_im = '0; s_last = 1'b0; m_ready = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_s_ready", int'(s_ready), 0);
        check("rst_m_valid", int'(m_valid), 0);
        check("rst_fft_en", int'(fft_en), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_frame_err", int'(frame_err), 0);
        check("rst_frame_cnt", int'(frame_cnt), 0);
        check("rst_m_re", int'(m_re), 0);
        check("rst_m_idx", int'(m_idx), 0);
        check("rst_m_last", int'(m_last), 0);
        rst = 1'b0;
        @(negedge clk);
        check("ready_after_rst", int'(s_ready), 1);

        // Impulse
        set_frame(0);
        en0 = en_cycles;
        send(8, 7);
        pull("imp", 8, 1'b0);
        check("imp_en_cycles", en_cycles - en0, 2);
        check("imp_frame_cnt", int'(frame_cnt), 1);
        check("imp_valid_after", int'(m_valid), 0);

        // DC, with s_ready timing around the frame
        set_frame(1);
        en0 = en_cycles;
        send(8, 7);
        check("dc_ready_after_accept", int'(s_ready), 0);
        check("dc_busy_after_accept", int'(busy), 1);
        pull("dc", 8, 1'b0);
        check("dc_ready_after_last", int'(s_ready), 1);
        check("dc_valid_after_last", int'(m_valid), 0);
        check("dc_en_cycles", en_cycles - en0, 2);
        check("dc_frame_cnt", int'(frame_cnt), 2);

        // Backpressure 1,0,0,1
        set_frame(2);
        send(8, 7);
        pull("bp", 8, 1'b1);
        check("bp_valid_after", int'(m_valid), 0);
        check("bp_frame_cnt", int'(frame_cnt), 3);

        // Short frame: s_last on the 5th sample
        en0 = en_cycles; err0 = err_cycles;
        for (int i = 0; i < 5; i++) push(99, -7, i == 4);
        repeat (3) @(negedge clk);
        check("short_err_cycles", err_cycles - err0, 1);
        check("short_no_en", en_cycles - en0, 0);
        check("short_ready", int'(s_ready), 1);
        set_frame(3);
        en0 = en_cycles;
        send(8, 7);
        pull("after_short", 8, 1'b0);
        check("after_short_en", en_cycles - en0, 2);
        check("after_short_cnt", int'(frame_cnt), 4);

        // Long frame: 8 samples without s_last, then 3 more ending the frame
        en0 = en_cycles; err0 = err_cycles;
        for (int i = 0; i < 8; i++) push(50, 5, 1'b0);
        for (int i = 0; i < 3; i++) push(77, -3, i == 2);
        repeat (3) @(negedge clk);
        check("long_err_cycles", err_cycles - err0, 1);
        check("long_no_en", en_cycles - en0, 0);
        check("long_busy", int'(busy), 0);
        set_frame(2);
        send(8, 7);
        pull("after_long", 8, 1'b0);
        check("after_long_cnt", int'(frame_cnt), 5);

        // Reset in the middle of UNLOAD after 3 outputs
        set_frame(0);
        send(8, 7);
        pull("pre_rst", 3, 1'b0);
        rst = 1'b1;
        #1;
        check("midrst_m_valid", int'(m_valid), 0);
        check("midrst_frame_cnt", int'(frame_cnt), 0);
        check("midrst_busy", int'(busy), 0);
        check("midrst_s_ready", int'(s_ready), 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        set_frame(1);
        en0 = en_cycles;
        send(8, 7);
        pull("post_rst", 8, 1'b0);
        check("post_rst_en", en_cycles - en0, 2);
        check("post_rst_cnt", int'(frame_cnt), 1);

        check("protocol_violations", viol, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
